// File: rtl/ibufds_gte_div.sv
// GT reference-clock input buffer model with synchronous reset, programmable
// enable delay and an integer divider on ODIV that always stops with ODIV low.
module ibufds_gte_div #(
    parameter logic       REFCLK_EN_TX_PATH  = 1'b0,
    parameter logic [1:0] REFCLK_HROW_CK_SEL = 2'b00,
    parameter int         DIV_W              = 4,
    parameter int         DIV_DEFAULT        = 2,
    parameter int         EN_DELAY           = 8
) (
    input  logic             I,
    input  logic             RST,
    input  logic             IB,
    input  logic             CEB,
    input  logic [DIV_W-1:0] DIV_SEL,
    output logic             O,
    output logic             ODIV,
    output logic             RDY
);

    typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_RUN, ST_DRAIN} StateE;

    localparam logic             DIV_MODE = (REFCLK_HROW_CK_SEL == 2'b01) ||
                                            (REFCLK_HROW_CK_SEL == 2'b10);
    localparam logic [7:0]       DLY_LAST = (EN_DELAY > 0) ? 8'(EN_DELAY - 1) : 8'd0;
    localparam logic [DIV_W-1:0] N_MIN    = DIV_W'(2);
    localparam logic [DIV_W-1:0] N_DEF    = DIV_W'(DIV_DEFAULT);

    StateE            r_state;
    StateE            w_stateNext;
    logic [7:0]       r_dly;
    logic [7:0]       w_dlyNext;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_n;
    logic             r_odiv;
    logic             r_oen;
    logic             r_rdy;
    logic             w_oenNext;
    logic             w_rdyNext;
    logic [DIV_W-1:0] w_nRaw;
    logic [DIV_W-1:0] w_nSel;
    logic [DIV_W-1:0] w_cntInc;
    logic             w_wrap;
    logic             w_runEntry;
    logic             w_unusedIb;

    assign w_unusedIb = IB;

    assign w_nRaw     = (REFCLK_HROW_CK_SEL == 2'b10) ? DIV_SEL : N_DEF;
    assign w_nSel     = (w_nRaw < N_MIN) ? N_MIN : w_nRaw;
    assign w_cntInc   = r_cnt + DIV_W'(1);
    assign w_wrap     = (r_cnt == (r_n - DIV_W'(1)));
    assign w_runEntry = (r_state != ST_RUN) && (w_stateNext == ST_RUN);

    always_ff @(posedge I) begin
        if (RST) begin
            r_state <= ST_OFF;
            r_dly   <= 8'd0;
            r_oen   <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_dly   <= w_dlyNext;
            r_oen   <= w_oenNext;
            r_rdy   <= w_rdyNext;
        end
    end

    // DRAIN ignores CEB entirely so a running ODIV period is never cut short.
    always_comb begin
        w_stateNext = r_state;
        w_dlyNext   = r_dly;
        case (r_state)
            ST_OFF: begin
                w_dlyNext = 8'd0;
                if (!CEB) begin
                    w_stateNext = (EN_DELAY == 0) ? ST_RUN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (CEB) begin
                    w_stateNext = ST_OFF;
                    w_dlyNext   = 8'd0;
                end else if (r_dly == DLY_LAST) begin
                    w_stateNext = ST_RUN;
                    w_dlyNext   = 8'd0;
                end else begin
                    w_dlyNext = r_dly + 8'd1;
                end
            end
            ST_RUN: begin
                if (CEB) begin
                    w_stateNext = DIV_MODE ? ST_DRAIN : ST_OFF;
                end
            end
            ST_DRAIN: begin
                if (w_wrap) begin
                    w_stateNext = ST_OFF;
                end
            end
            default: begin
                w_stateNext = ST_OFF;
                w_dlyNext   = 8'd0;
            end
        endcase
    end

    always_comb begin
        w_rdyNext = (w_stateNext == ST_RUN) && !REFCLK_EN_TX_PATH;
        w_oenNext = w_rdyNext && (REFCLK_HROW_CK_SEL != 2'b11);
    end

    // The ratio is re-latched only at a wrap, so DIV_SEL changes land on period boundaries.
    always_ff @(posedge I) begin
        if (RST || !DIV_MODE) begin
            r_cnt  <= '0;
            r_odiv <= 1'b0;
            r_n    <= N_MIN;
        end else if (w_runEntry) begin
            r_cnt  <= '0;
            r_odiv <= 1'b1;
            r_n    <= w_nSel;
        end else if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) begin
            if (w_wrap) begin
                r_cnt  <= '0;
                r_odiv <= (r_state == ST_RUN);
                r_n    <= w_nSel;
            end else begin
                r_cnt  <= w_cntInc;
                r_odiv <= (w_cntInc < (r_n >> 1));
            end
        end else begin
            r_cnt  <= '0;
            r_odiv <= 1'b0;
        end
    end

    assign O   = I & r_oen;
    assign RDY = r_rdy;

    always_comb begin
        ODIV = 1'b0;
        if (!REFCLK_EN_TX_PATH) begin
            case (REFCLK_HROW_CK_SEL)
                2'b00:   ODIV = O;
                2'b01,
                2'b10:   ODIV = r_odiv;
                default: ODIV = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ibufds_gte_div.sv
// Directed bench for ibufds_gte_div: one instance per parameter set sharing a
// common reference clock, with hand-computed expected waveforms.
module tb_ibufds_gte_div;

   logic       refClk = 1'b0;
   logic       refClkB;
   logic [4:0] rst    = 5'b11111;
   logic [4:0] ceb    = 5'b11111;
   logic [3:0] divSel = 4'd3;
   logic [3:0] divZero = 4'd0;
   logic [4:0] o;
   logic [4:0] odiv;
   logic [4:0] rdy;

   int numChecks = 0;
   int numFails  = 0;

   // Free-running reference clock, 10 time units per period
   always #5 refClk = ~refClk;
   assign refClkB = ~refClk;

   ibufds_gte_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b00), .DIV_W(4),
                    .DIV_DEFAULT(2), .EN_DELAY(8)) u0 (
      .I(refClk), .RST(rst[0]), .IB(refClkB), .CEB(ceb[0]), .DIV_SEL(divZero),
      .O(o[0]), .ODIV(odiv[0]), .RDY(rdy[0]));

   ibufds_gte_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b01), .DIV_W(4),
                    .DIV_DEFAULT(4), .EN_DELAY(2)) u1 (
      .I(refClk), .RST(rst[1]), .IB(refClkB), .CEB(ceb[1]), .DIV_SEL(divZero),
      .O(o[1]), .ODIV(odiv[1]), .RDY(rdy[1]));

   ibufds_gte_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b10), .DIV_W(4),
                    .DIV_DEFAULT(2), .EN_DELAY(1)) u2 (
      .I(refClk), .RST(rst[2]), .IB(refClkB), .CEB(ceb[2]), .DIV_SEL(divSel),
      .O(o[2]), .ODIV(odiv[2]), .RDY(rdy[2]));

   ibufds_gte_div #(.REFCLK_EN_TX_PATH(1'b1), .REFCLK_HROW_CK_SEL(2'b01), .DIV_W(4),
                    .DIV_DEFAULT(2), .EN_DELAY(1)) u3 (
      .I(refClk), .RST(rst[3]), .IB(refClkB), .CEB(ceb[3]), .DIV_SEL(divZero),
      .O(o[3]), .ODIV(odiv[3]), .RDY(rdy[3]));

   ibufds_gte_div #(.REFCLK_EN_TX_PATH(1'b0), .REFCLK_HROW_CK_SEL(2'b11), .DIV_W(4),
                    .DIV_DEFAULT(2), .EN_DELAY(0)) u4 (
      .I(refClk), .RST(rst[4]), .IB(refClkB), .CEB(ceb[4]), .DIV_SEL(divZero),
      .O(o[4]), .ODIV(odiv[4]), .RDY(rdy[4]));

   // Counts one comparison and reports it if the observed value differs
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drives reset and clock-enable of one instance
   task automatic applyStimulus(input int idx, input logic rstV, input logic cebV);
      rst[idx] = rstV;
      ceb[idx] = cebV;
   endtask

   // Advances to just after the next rising edge (I high)
   task automatic tick();
      @(posedge refClk);
      #1;
   endtask

   // Advances to just after the next falling edge (I low)
   task automatic lowPhase();
      @(negedge refClk);
      #1;
   endtask

   // Expected ODIV after edges 0..12 for N=3, then N=5, then N=2 (DIV_SEL=1 clamped)
   logic t3Odiv [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                         1'b1, 1'b0, 1'b1, 1'b0};
   // Expected RDY/ODIV after edges 0..9 for the N=6 drain sequence
   logic t4Rdy  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic t4Odiv [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   // Directed sequence covering enable delay, divider modes, drain, reset and tx-path tie-off
   initial begin
      $display("[TB] start");

      applyStimulus(0, 1'b1, 1'b0);
      tick();
      checkOutput("t1 reset rdy", 32'(rdy[0]), 32'd0);
      checkOutput("t1 reset o", 32'(o[0]), 32'd0);
      checkOutput("t1 reset odiv", 32'(odiv[0]), 32'd0);
      applyStimulus(0, 1'b0, 1'b0);
      for (int k = 0; k <= 8; k++) begin
         tick();
         checkOutput($sformatf("t1 rdy e%0d", k), 32'(rdy[0]), 32'(k == 8));
         checkOutput($sformatf("t1 o high e%0d", k), 32'(o[0]), 32'(k == 8));
      end
      checkOutput("t1 odiv high", 32'(odiv[0]), 32'd1);
      lowPhase();
      checkOutput("t1 o low", 32'(o[0]), 32'd0);
      checkOutput("t1 odiv low", 32'(odiv[0]), 32'd0);

      applyStimulus(0, 1'b1, 1'b0);
      tick();
      applyStimulus(0, 1'b0, 1'b0);
      for (int k = 0; k <= 5; k++) tick();
      checkOutput("t5 wait rdy", 32'(rdy[0]), 32'd0);
      applyStimulus(0, 1'b0, 1'b1);
      tick();
      checkOutput("t5 off rdy", 32'(rdy[0]), 32'd0);
      applyStimulus(0, 1'b0, 1'b0);
      for (int j = 0; j <= 8; j++) begin
         tick();
         checkOutput($sformatf("t5 rdy e%0d", j), 32'(rdy[0]), 32'(j == 8));
      end

      applyStimulus(1, 1'b1, 1'b0);
      tick();
      applyStimulus(1, 1'b0, 1'b0);
      for (int k = 0; k <= 9; k++) begin
         tick();
         checkOutput($sformatf("t2 rdy e%0d", k), 32'(rdy[1]), 32'(k >= 2));
         checkOutput($sformatf("t2 odiv e%0d", k), 32'(odiv[1]),
                     32'((k >= 2) && (((k - 2) % 4) < 2)));
         checkOutput($sformatf("t2 o e%0d", k), 32'(o[1]), 32'(k >= 2));
      end

      divSel = 4'd3;
      applyStimulus(2, 1'b1, 1'b0);
      tick();
      applyStimulus(2, 1'b0, 1'b0);
      for (int k = 0; k <= 12; k++) begin
         tick();
         checkOutput($sformatf("t3 odiv e%0d", k), 32'(odiv[2]), 32'(t3Odiv[k]));
         if (k == 2) divSel = 4'd5;
         if (k == 5) divSel = 4'd1;
      end

      divSel = 4'd6;
      applyStimulus(2, 1'b1, 1'b0);
      tick();
      applyStimulus(2, 1'b0, 1'b0);
      for (int k = 0; k <= 9; k++) begin
         tick();
         checkOutput($sformatf("t4 rdy e%0d", k), 32'(rdy[2]), 32'(t4Rdy[k]));
         checkOutput($sformatf("t4 odiv e%0d", k), 32'(odiv[2]), 32'(t4Odiv[k]));
         if (k == 3) checkOutput("t4 drain o", 32'(o[2]), 32'd0);
         if (k == 2) applyStimulus(2, 1'b0, 1'b1);
         if (k == 3) applyStimulus(2, 1'b0, 1'b0);
      end

      applyStimulus(2, 1'b0, 1'b1);
      tick();
      checkOutput("t6 drain odiv", 32'(odiv[2]), 32'd1);
      checkOutput("t6 drain rdy", 32'(rdy[2]), 32'd0);
      applyStimulus(2, 1'b1, 1'b1);
      tick();
      checkOutput("t6 rst odiv", 32'(odiv[2]), 32'd0);
      checkOutput("t6 rst rdy", 32'(rdy[2]), 32'd0);
      checkOutput("t6 rst o", 32'(o[2]), 32'd0);
      applyStimulus(2, 1'b0, 1'b1);
      tick();
      checkOutput("t6 off odiv", 32'(odiv[2]), 32'd0);

      applyStimulus(3, 1'b1, 1'b0);
      tick();
      applyStimulus(3, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         checkOutput($sformatf("t6 txpath e%0d", k), {29'd0, o[3], odiv[3], rdy[3]}, 32'd0);
      end

      applyStimulus(4, 1'b1, 1'b0);
      tick();
      checkOutput("m11 reset rdy", 32'(rdy[4]), 32'd0);
      applyStimulus(4, 1'b0, 1'b0);
      tick();
      checkOutput("m11 rdy", 32'(rdy[4]), 32'd1);
      checkOutput("m11 o", 32'(o[4]), 32'd0);
      checkOutput("m11 odiv", 32'(odiv[4]), 32'd0);

      $display("test done: total=%0d bad=%0d", numChecks, numFails);
      $finish;
   end

endmodule
